timer_bank: RTL and testbench
=============================

# timer_bank

Parametrised multi-channel countdown timer bank with a free-running uptime counter, the successor to the single 16-bit millisecond timer. A shared prescaler derives a tick from the system clock. CHN independent channels count down on that tick in one-shot or periodic mode and raise per-channel expiry flags and a combined interrupt. It sits on the CPU register bus beside sys_status and is driven by the synchronised write/read strobes.

## Interface
- CLK_HZ, 50000000: system clock frequency.
- TICK_HZ, 1000: tick rate. DIV = CLK_HZ/TICK_HZ must be ≥2 and integer.
- CHN, 4: channel count, 1..7.
- TW, 16: counter width, one of 8/16/24/32. NB = TW/8 bytes.

- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- addr  in  6  addr[5:3] = channel (7 = global), addr[2:0] = register
- dati  in  8  write data
- we  in  1  one-cycle write strobe (already synchronised)
- rd  in  1  one-cycle read strobe (already synchronised)
- dato  out  8  read data, registered
- tick  out  1  one-cycle pulse per prescaler period
- irq  out  1  OR over channels of (expired & irq_en), registered

## Operation
- Prescaler: counts 0..DIV-1. tick=1 on the cycle the count equals DIV-1, then wraps to 0.
- Channel registers (addr[5:3]=c, c<CHN):
  - r0..r(NB-1): write sets reload byte. A read of r0 returns count byte0 and snapshots the whole count. r1..r(NB-1) return snapshot bytes. Bytes ≥NB read 0.
  - r4 ctrl: bit0 en, bit1 periodic, bit2 irq_en. Write bit7=1 also loads count<=reload. Read gives {expired, 4'b0, irq_en, periodic, en}.
  - r5 status: read bit0=expired. Writing 1 to bit0 clears expired.
- Global (addr[5:3]=7):
  - r0..r3: uptime counter, 32-bit, +1 per tick, wraps. Same snapshot-on-r0 rule.
  - r5: any write clears the prescaler and uptime.
- Unmapped reads return 8'h00. Unmapped writes are ignored.
- Channel at tick with en=1:
  - count>1: count-1.
  - count==1: expired<=1. count<=periodic ? reload : 0. One-shot clears en.
  - count==0: no change. No expiry, including periodic mode with reload=0.
- en=0: the count holds.

## Timing
- Reset (rst_n=0 at a clk edge): all registers, counts, flags, snapshots, the prescaler and uptime go to 0. dato=0, tick=0, irq=0. Reset mid-count discards everything.
- Write: takes effect at the edge where we=1. Visible on the following read.
- Read: dato is valid the cycle after rd and holds until the next rd. Snapshot is captured at the same edge.
- irq: follows the expired/irq_en state with 1 cycle latency.
- Expiry: expired is set at the tick edge where count goes 1→0 (or reloads).
- Priority, same cycle:
  - Status clear vs. expiry: expiry wins, flag stays 1.
  - Ctrl load (bit7) vs. tick on that channel: the load wins and the tick is skipped for that channel.
  - Global r5 clear vs. tick: the clear wins and no tick is emitted.
  - Reload-byte write vs. periodic reload: the reload uses the old value and the new byte lands in reload.
- Periodic period is exactly reload ticks. One-shot expires exactly reload ticks after load+enable.

## Test plan
- CLK_HZ=1000, TICK_HZ=100 (DIV=10): release reset -> tick every 10 clocks, first at clock 10. Uptime reads 5 after 50 clocks.
- Ch0, TW=16: reload=0x0003, ctrl=0x87 (load, en, periodic, irq_en) -> expired and irq after 3 ticks, again after 6. Write status 0x01 -> irq drops 1 cycle later.
- Ch1 one-shot: reload=2, ctrl=0x81 -> expires after 2 ticks, en reads 0, count stays 0, no further expiry.
- Atomic read: ch2 count=0x0100, tick between r0 and r1 reads -> r0=0x00, r1=0x01 (snapshot), not 0x00.
- Simultaneous: status-clear write on the expiry tick -> expired stays 1. Ctrl 0x81 on a tick edge -> count=reload, no decrement.
- Reset asserted mid-count with irq high -> all reads 0, irq=0 next cycle. Reload=0 periodic -> never expires.

Source files
------------

// File: rtl/timer_bank.sv
// Multi-channel countdown timer bank with shared prescaler and 32-bit uptime counter.
// Register-bus slave: addr[5:3] selects a channel (7 = global), addr[2:0] the register.

module timer_chan #(
   parameter int TW = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sel,
   input  logic [2:0] reg_a,
   input  logic [7:0] dati,
   input  logic       we,
   input  logic       rd,
   input  logic       tick,
   output logic [7:0] rdata,
   output logic       irq_req
);
   localparam int NB = TW / 8;

   logic [TW-1:0] reload, count, snap;
   logic [31:0]   snap_w;
   logic          en, periodic, irq_en, expired;
   logic          wr_ctrl, load, wr_stat, snap_en;

   assign wr_ctrl = we && sel && (reg_a == 3'd4);
   assign load    = wr_ctrl && dati[7];
   assign wr_stat = we && sel && (reg_a == 3'd5);
   assign snap_en = rd && sel && (reg_a == 3'd0);
   assign snap_w  = 32'(snap);
   assign irq_req = expired && irq_en;

   // Statement order carries the same-cycle priorities: expiry overrides a status
   // clear, a ctrl load replaces the tick, and a ctrl write overrides the one-shot en drop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reload   <= '0;
         count    <= '0;
         snap     <= '0;
         en       <= 1'b0;
         periodic <= 1'b0;
         irq_en   <= 1'b0;
         expired  <= 1'b0;
      end else begin
         for (int b = 0; b < NB; b++)
            if (we && sel && (reg_a == 3'(b))) reload[8*b +: 8] <= dati;
         if (snap_en) snap <= count;
         if (wr_stat && dati[0]) expired <= 1'b0;
         if (load) begin
            count <= reload;
         end else if (tick && en) begin
            if (count > TW'(1)) begin
               count <= count - TW'(1);
            end else if (count == TW'(1)) begin
               expired <= 1'b1;
               count   <= periodic ? reload : '0;
               if (!periodic) en <= 1'b0;
            end
         end
         if (wr_ctrl) begin
            en       <= dati[0];
            periodic <= dati[1];
            irq_en   <= dati[2];
         end
      end
   end

   // Byte 0 is the live count; the upper bytes come from the snapshot taken with it.
   always_comb begin
      rdata = 8'h00;
      case (reg_a)
         3'd0:                rdata = count[7:0];
         3'd1, 3'd2, 3'd3:    rdata = snap_w[{reg_a[1:0], 3'b000} +: 8];
         3'd4:                rdata = {expired, 4'b0000, irq_en, periodic, en};
         3'd5:                rdata = {7'b0000000, expired};
         default:             rdata = 8'h00;
      endcase
   end
endmodule

module timer_bank #(
   parameter int CLK_HZ  = 50000000,
   parameter int TICK_HZ = 1000,
   parameter int CHN     = 4,
   parameter int TW      = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] addr,
   input  logic [7:0] dati,
   input  logic       we,
   input  logic       rd,
   output logic [7:0] dato,
   output logic       tick,
   output logic       irq
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [2:0]            ch_a, reg_a;
   logic [PW-1:0]         pcnt;
   logic [31:0]           uptime, up_snap;
   logic                  g_sel, gclr, tick_i;
   logic [CHN-1:0][7:0]   ch_rdata;
   logic [CHN-1:0]        ch_irq;
   logic [7:0]            rnext;

   assign ch_a  = addr[5:3];
   assign reg_a = addr[2:0];
   assign g_sel = (ch_a == 3'd7);
   assign gclr  = we && g_sel && (reg_a == 3'd5);

   // A global clear on the terminal count swallows that tick.
   assign tick_i = rst_n && !gclr && (pcnt == PW'(DIV - 1));
   assign tick   = tick_i;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pcnt   <= '0;
         uptime <= '0;
      end else if (gclr) begin
         pcnt   <= '0;
         uptime <= '0;
      end else if (tick_i) begin
         pcnt   <= '0;
         uptime <= uptime + 32'd1;
      end else begin
         pcnt   <= pcnt + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         up_snap <= '0;
      else if (rd && g_sel && (reg_a == 3'd0))
         up_snap <= uptime;
   end

   genvar g;
   generate
      for (g = 0; g < CHN; g++) begin : g_ch
         timer_chan #(.TW(TW)) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .sel     (ch_a == 3'(g)),
            .reg_a   (reg_a),
            .dati    (dati),
            .we      (we),
            .rd      (rd),
            .tick    (tick_i),
            .rdata   (ch_rdata[g]),
            .irq_req (ch_irq[g])
         );
      end
   endgenerate

   always_comb begin
      rnext = 8'h00;
      if (g_sel) begin
         case (reg_a)
            3'd0:             rnext = uptime[7:0];
            3'd1, 3'd2, 3'd3: rnext = up_snap[{reg_a[1:0], 3'b000} +: 8];
            default:          rnext = 8'h00;
         endcase
      end else begin
         for (int c = 0; c < CHN; c++)
            if (ch_a == 3'(c)) rnext = ch_rdata[c];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dato <= 8'h00;
         irq  <= 1'b0;
      end else begin
         irq <= |ch_irq;
         if (rd) dato <= rnext;
      end
   end
endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank at DIV=10, CHN=4, TW=16: register vector table plus
// hand sequences around tick edges; read results go through an expectation queue.

module tb_timer_bank;
   logic       clk, rst_n, we, rd, tick, irq;
   logic [5:0] addr;
   logic [7:0] dati, dato;

   typedef struct {
      logic       w;
      logic [5:0] a;
      logic [7:0] d;
      string      nm;
   } vec_t;

   typedef struct {
      logic [7:0] exp;
      string      nm;
   } sb_t;

   vec_t tbl[$];
   sb_t  sbq[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_rst;

   timer_bank #(.CLK_HZ(1000), .TICK_HZ(100), .CHN(4), .TW(16)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .dati(dati), .we(we), .rd(rd),
      .dato(dato), .tick(tick), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic wr_now(input logic [5:0] a, input logic [7:0] d);
      addr = a; dati = d; we = 1'b1;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic wr(input logic [5:0] a, input logic [7:0] d);
      @(negedge clk);
      wr_now(a, d);
   endtask

   task automatic rdc(input logic [5:0] a, input logic [7:0] e, input string nm);
      sb_t s;
      @(negedge clk);
      addr = a; rd = 1'b1;
      s.exp = e; s.nm = nm;
      sbq.push_back(s);
      @(negedge clk);
      rd = 1'b0;
      s = sbq.pop_front();
      chk(s.nm, dato, s.exp);
   endtask

   // Leaves time parked just after a negedge whose following posedge is a tick edge.
   task automatic wait_tick();
      int k = 0;
      #1;
      while (tick !== 1'b1 && k < 40) begin
         @(negedge clk); #1;
         k++;
      end
      if (tick !== 1'b1) begin
         n_chk++; n_fail++;
         $display("FAIL tick_timeout: got no tick, want one within 40 cycles");
      end
   endtask

   task automatic next_tick();
      wait_tick();
      @(negedge clk);
   endtask

   task automatic run_table(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         if (tbl[i].w) wr(tbl[i].a, tbl[i].d);
         else          rdc(tbl[i].a, tbl[i].d, tbl[i].nm);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, want finish before 2 ms");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset-state reads (rows 0..n_rst-1), reused after the mid-count reset.
      tbl.push_back('{1'b0, 6'h38, 8'h00, "rst_up0"});
      tbl.push_back('{1'b0, 6'h39, 8'h00, "rst_up1"});
      tbl.push_back('{1'b0, 6'h3A, 8'h00, "rst_up2"});
      tbl.push_back('{1'b0, 6'h3B, 8'h00, "rst_up3"});
      tbl.push_back('{1'b0, 6'h00, 8'h00, "rst_c0r0"});
      tbl.push_back('{1'b0, 6'h01, 8'h00, "rst_c0r1"});
      tbl.push_back('{1'b0, 6'h04, 8'h00, "rst_c0ctl"});
      tbl.push_back('{1'b0, 6'h05, 8'h00, "rst_c0st"});
      tbl.push_back('{1'b0, 6'h08, 8'h00, "rst_c1r0"});
      tbl.push_back('{1'b0, 6'h0C, 8'h00, "rst_c1ctl"});
      tbl.push_back('{1'b0, 6'h0D, 8'h00, "rst_c1st"});
      tbl.push_back('{1'b0, 6'h14, 8'h00, "rst_c2ctl"});
      tbl.push_back('{1'b0, 6'h1C, 8'h00, "rst_c3ctl"});
      tbl.push_back('{1'b0, 6'h1D, 8'h00, "rst_c3st"});
      n_rst = tbl.size();
      // Register map: ctrl readback, unmapped slots, reload/load/snapshot.
      tbl.push_back('{1'b1, 6'h04, 8'h06, ""});
      tbl.push_back('{1'b0, 6'h04, 8'h06, "c0ctl_rb"});
      tbl.push_back('{1'b1, 6'h0C, 8'h05, ""});
      tbl.push_back('{1'b0, 6'h0C, 8'h05, "c1ctl_rb"});
      tbl.push_back('{1'b1, 6'h14, 8'h02, ""});
      tbl.push_back('{1'b0, 6'h14, 8'h02, "c2ctl_rb"});
      tbl.push_back('{1'b0, 6'h1C, 8'h00, "c3ctl_untouched"});
      tbl.push_back('{1'b0, 6'h06, 8'h00, "c0r6_unmapped"});
      tbl.push_back('{1'b0, 6'h07, 8'h00, "c0r7_unmapped"});
      tbl.push_back('{1'b0, 6'h02, 8'h00, "c0r2_beyond_nb"});
      tbl.push_back('{1'b0, 6'h03, 8'h00, "c0r3_beyond_nb"});
      tbl.push_back('{1'b0, 6'h20, 8'h00, "ch4_absent"});
      tbl.push_back('{1'b1, 6'h24, 8'h07, ""});
      tbl.push_back('{1'b0, 6'h24, 8'h00, "ch4_wr_ignored"});
      tbl.push_back('{1'b0, 6'h3C, 8'h00, "g_r4_unmapped"});
      tbl.push_back('{1'b0, 6'h3E, 8'h00, "g_r6_unmapped"});
      tbl.push_back('{1'b0, 6'h3F, 8'h00, "g_r7_unmapped"});
      tbl.push_back('{1'b1, 6'h00, 8'h2A, ""});
      tbl.push_back('{1'b1, 6'h04, 8'h80, ""});
      tbl.push_back('{1'b0, 6'h00, 8'h2A, "c0_load_b0"});
      tbl.push_back('{1'b0, 6'h01, 8'h00, "c0_load_b1"});
      tbl.push_back('{1'b0, 6'h04, 8'h00, "c0ctl_after_load"});
      tbl.push_back('{1'b1, 6'h01, 8'h12, ""});
      tbl.push_back('{1'b1, 6'h04, 8'h80, ""});
      tbl.push_back('{1'b0, 6'h00, 8'h2A, "c0_load2_b0"});
      tbl.push_back('{1'b0, 6'h01, 8'h12, "c0_load2_b1"});
      tbl.push_back('{1'b1, 6'h0C, 8'h00, ""});
      tbl.push_back('{1'b1, 6'h14, 8'h00, ""});

      rst_n = 1'b0; we = 1'b0; rd = 1'b0; addr = '0; dati = '0;
      repeat (3) @(negedge clk);
      chk("rst_dato", dato, 0);
      chk("rst_tick", tick, 0);
      chk("rst_irq", irq, 0);

      // Prescaler cadence from reset release: tick in cycle 10, 20, ...
      rst_n = 1'b1;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         chk($sformatf("tick_c%0d", k), tick, (k % 10) == 9);
      end
      rdc(6'h38, 8'd5, "uptime_50clk");
      rdc(6'h39, 8'd0, "uptime_50clk_b1");

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_table(0, tbl.size() - 1);

      // Global clear on a tick cycle: no tick, prescaler restarts.
      wait_tick();
      addr = 6'h3D; dati = 8'h00; we = 1'b1;
      #1 chk("gclr_tick_suppressed", tick, 0);
      @(negedge clk);
      we = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         chk($sformatf("gclr_tick_c%0d", k), tick, k == 9);
      end
      rdc(6'h38, 8'd1, "uptime_after_gclr");
      rdc(6'h39, 8'd0, "uptime_after_gclr_b1");

      // Ch0 periodic, reload 3.
      wr(6'h00, 8'h03); wr(6'h01, 8'h00); wr(6'h04, 8'h87);
      next_tick();
      rdc(6'h00, 8'd2, "c0_cnt_t1");
      next_tick();
      next_tick();
      chk("c0_irq_latency", irq, 0);
      @(negedge clk);
      chk("c0_irq_t3", irq, 1);
      rdc(6'h05, 8'h01, "c0_exp_t3");
      wr(6'h05, 8'h01);
      chk("c0_irq_hold_after_clr", irq, 1);
      @(negedge clk);
      chk("c0_irq_drop", irq, 0);
      next_tick();
      next_tick();
      rdc(6'h05, 8'h00, "c0_exp_t5");
      next_tick();
      rdc(6'h05, 8'h01, "c0_exp_t6");
      rdc(6'h00, 8'd3, "c0_reloaded");
      wr(6'h04, 8'h00); wr(6'h05, 8'h01);
      @(negedge clk);
      chk("c0_irq_off", irq, 0);

      // Ch1 one-shot, reload 2.
      wr(6'h08, 8'h02); wr(6'h09, 8'h00); wr(6'h0C, 8'h81);
      next_tick();
      rdc(6'h08, 8'd1, "c1_cnt_t1");
      next_tick();
      rdc(6'h0D, 8'h01, "c1_exp");
      rdc(6'h0C, 8'h80, "c1_en_cleared");
      rdc(6'h08, 8'd0, "c1_cnt_zero");
      wr(6'h0D, 8'h01);
      next_tick();
      next_tick();
      rdc(6'h0D, 8'h00, "c1_no_reexpire");
      rdc(6'h08, 8'd0, "c1_cnt_stays");
      chk("c1_no_irq", irq, 0);

      // Ctrl load on a tick edge: load wins, no decrement.
      wr(6'h08, 8'h05);
      wait_tick();
      wr_now(6'h0C, 8'h81);
      rdc(6'h08, 8'd5, "c1_load_on_tick");
      next_tick();
      rdc(6'h08, 8'd4, "c1_after_load_tick");
      wr(6'h0C, 8'h00);

      // Ch2 atomic multi-byte read across a tick.
      wr(6'h10, 8'h00); wr(6'h11, 8'h01); wr(6'h14, 8'h80);
      next_tick();
      wr(6'h14, 8'h01);
      rdc(6'h10, 8'h00, "c2_r0_snap");
      next_tick();
      rdc(6'h11, 8'h01, "c2_r1_from_snap");
      rdc(6'h10, 8'hFF, "c2_r0_live");
      rdc(6'h11, 8'h00, "c2_r1_new_snap");
      wr(6'h14, 8'h00);

      // Ch3 reload 1: status clear and reload-byte write on expiry ticks.
      wr(6'h18, 8'h01); wr(6'h19, 8'h00);
      next_tick();
      wr(6'h1C, 8'h83);
      wait_tick();
      wr_now(6'h1D, 8'h01);
      rdc(6'h1D, 8'h01, "c3_expiry_beats_clear");
      wait_tick();
      wr_now(6'h18, 8'h04);
      rdc(6'h18, 8'd1, "c3_reload_uses_old");
      next_tick();
      rdc(6'h18, 8'd4, "c3_reload_uses_new");
      wr(6'h1C, 8'h00); wr(6'h1D, 8'h01);
      @(negedge clk);
      chk("c3_irq_off", irq, 0);

      // Periodic with reload 0 never expires.
      wr(6'h00, 8'h00); wr(6'h01, 8'h00); wr(6'h04, 8'h87); wr(6'h05, 8'h01);
      repeat (3) next_tick();
      rdc(6'h05, 8'h00, "c0_rel0_no_exp");
      rdc(6'h04, 8'h07, "c0_rel0_ctl");
      rdc(6'h00, 8'h00, "c0_rel0_cnt");
      chk("c0_rel0_no_irq", irq, 0);

      // Reset mid-count with irq high.
      wr(6'h00, 8'h01); wr(6'h04, 8'h87);
      wr(6'h08, 8'h10); wr(6'h0C, 8'h81);
      next_tick();
      @(negedge clk);
      chk("pre_rst_irq", irq, 1);
      rdc(6'h04, 8'h87, "pre_rst_c0ctl");
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_irq", irq, 0);
      chk("midrst_dato", dato, 0);
      chk("midrst_tick", tick, 0);
      rst_n = 1'b1;
      run_table(0, n_rst - 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
